spdp_bitmem: RTL

Parametrised bit-serial main memory for the serial PDP-8 system, the next generation of the system's bit-addressed memory. It keeps single-bit read/write by word and bit address, adds a clocked word-burst engine that streams a whole word in or out one bit per cycle, and adds an optional zero-fill sequencer after reset. It sits between `pdp8_cpu` and the storage array inside `pdp8_system`. All behaviour is synchronous to `sysclk`; there is no negedge write strobe.

---
 rtl/spdp_bitmem_if.sv | 27 ++
 rtl/spdp_bitmem.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/spdp_bitmem_if.sv
// Bus bundle between the PDP-8 CPU side (master) and the bit-serial memory (slave).
interface spdp_bitmem_if #(
   parameter int AW = 7,
   parameter int BW = 4
) ();
   logic [AW-1:0] ma;
   logic [BW-1:0] ba;
   logic          mb;
   logic          write;
   logic          start;
   logic          burst_wr;
   logic          membus;
   logic          busy;
   logic          bit_valid;
   logic          done;
   logic [BW-1:0] bcnt;

   modport master (
      output ma, ba, mb, write, start, burst_wr,
      input  membus, busy, bit_valid, done, bcnt
   );

   modport slave (
      input  ma, ba, mb, write, start, burst_wr,
      output membus, busy, bit_valid, done, bcnt
   );
endinterface

// File: rtl/spdp_bitmem.sv
// Bit-serial main memory: single-bit access, word-burst engine, optional zero-fill.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_CLEAR    | zero-filling word clr_addr, one word per cycle
// S_IDLE     | single-bit read every cycle, single write on request
// S_BURST_RD | streaming word baddr out, bit bcnt per cycle
// S_BURST_WR | streaming mb into word baddr, bit bcnt per cycle
module spdp_bitmem #(
   parameter int WIDTH          = 12,
   parameter int DEPTH          = 128,
   parameter int AW             = 7,
   parameter int BW             = 4,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic           sysclk,
   input logic           reset,
   spdp_bitmem_if.slave  bus
);
   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BURST_RD, S_BURST_WR} state_t;

   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [BW:0]   WIDTH_W  = (BW+1)'(WIDTH);
   localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam state_t        RST_ST   = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

   logic [WIDTH-1:0] mem [DEPTH];

   state_t        state, state_nxt;
   logic [AW-1:0] baddr, baddr_nxt;
   logic [AW-1:0] clr_addr, clr_nxt;
   logic [BW-1:0] bcnt_q, bcnt_nxt;
   // transfers left after the current one; terminal count 0 ends the burst
   logic [BW-1:0] remain, remain_nxt;
   logic          membus_q, membus_nxt;
   logic          valid_q, valid_nxt;
   logic          done_q, done_nxt;

   logic [AW-1:0] cur_a;
   logic [BW-1:0] cur_b;
   logic          in_range;
   logic          rd_bit;
   logic          bit_we;
   logic          clr_we;

   // address selection and range-guarded read of the addressed bit
   always_comb begin
      cur_a    = (state == S_IDLE) ? bus.ma : baddr;
      cur_b    = (state == S_IDLE) ? bus.ba : bcnt_q;
      in_range = ({1'b0, cur_a} < DEPTH_W) && ({1'b0, cur_b} < WIDTH_W);
      rd_bit   = in_range ? mem[cur_a][cur_b] : 1'b0;
   end

   // next-state and next-output decode
   always_comb begin
      state_nxt  = state;
      baddr_nxt  = baddr;
      clr_nxt    = clr_addr;
      bcnt_nxt   = bcnt_q;
      remain_nxt = remain;
      membus_nxt = membus_q;
      valid_nxt  = 1'b0;
      done_nxt   = 1'b0;
      bit_we     = 1'b0;
      clr_we     = 1'b0;
      case (state)
         S_CLEAR: begin
            clr_we = !reset;
            if (clr_addr == CLR_LAST) state_nxt = S_IDLE;
            else                      clr_nxt   = clr_addr + AW'(1);
         end
         S_IDLE: begin
            membus_nxt = rd_bit;
            if (bus.start) begin
               baddr_nxt  = bus.ma;
               bcnt_nxt   = bus.ba;
               remain_nxt = LAST_BIT;
               state_nxt  = bus.burst_wr ? S_BURST_WR : S_BURST_RD;
            end else if (bus.write) begin
               bit_we     = in_range && !reset;
               membus_nxt = bus.mb;
            end
         end
         S_BURST_RD, S_BURST_WR: begin
            valid_nxt = 1'b1;
            if (state == S_BURST_WR) begin
               bit_we     = in_range && !reset;
               membus_nxt = bus.mb;
            end else begin
               membus_nxt = rd_bit;
            end
            if (remain == '0) begin
               done_nxt  = 1'b1;
               bcnt_nxt  = '0;
               state_nxt = S_IDLE;
            end else begin
               remain_nxt = remain - BW'(1);
               bcnt_nxt   = (bcnt_q == LAST_BIT) ? '0 : bcnt_q + BW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // state and output registers with synchronous reset
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state    <= RST_ST;
         baddr    <= '0;
         clr_addr <= '0;
         bcnt_q   <= '0;
         remain   <= '0;
         membus_q <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         baddr    <= baddr_nxt;
         clr_addr <= clr_nxt;
         bcnt_q   <= bcnt_nxt;
         remain   <= remain_nxt;
         membus_q <= membus_nxt;
         valid_q  <= valid_nxt;
         done_q   <= done_nxt;
      end
   end

   // storage array: whole-word zero during clear, otherwise single-bit writes
   always_ff @(posedge sysclk) begin
      if (clr_we)      mem[clr_addr]     <= '0;
      else if (bit_we) mem[cur_a][cur_b] <= bus.mb;
   end

   assign bus.membus    = membus_q;
   assign bus.busy      = (state != S_IDLE);
   assign bus.bit_valid = valid_q;
   assign bus.done      = done_q;
   assign bus.bcnt      = bcnt_q;
endmodule
